// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use stall detection and bubble/flush counters.
// Latency: one cycle from ID inputs to every registered output; out_stall is combinational.
// Backpressure: in_hold freezes all state; out_stall holds PC and IF/ID for one cycle while a bubble enters EX.
module id_ex_stage #(
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              in_clk,
    input  logic              in_RST,
    input  logic              in_hold,
    input  logic              in_flush,
    input  logic [31:0]       in_A,
    input  logic [31:0]       in_B,
    input  logic [4:0]        in_ra,
    input  logic [4:0]        in_rb,
    input  logic              in_use_a,
    input  logic              in_use_b,
    input  logic [31:0]       in_IDPCOUT,
    input  logic [31:0]       in_IDIS,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [31:0]       in_ex_R,
    input  logic [31:0]       in_mem_R,
    input  logic [31:0]       in_wb_W,
    input  logic              in_mem_wr,
    input  logic              in_wb_wr,
    input  logic [4:0]        in_mem_rw,
    input  logic [4:0]        in_wb_rw,
    output logic [31:0]       out_A,
    output logic [31:0]       out_B,
    output logic [31:0]       out_PC,
    output logic [31:0]       out_IS,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [4:0]        out_rw,
    output logic              out_valid,
    output logic              out_stall,
    output logic [CNT_W-1:0]  out_bubbles,
    output logic [CNT_W-1:0]  out_flushes
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Forwarding source picker: EX beats MEM beats WB beats the register file; $0 is never forwarded.
    function automatic logic [31:0] pick_operand(
        input logic [4:0]  r,
        input logic [31:0] rf_d,
        input logic        ex_ok,
        input logic [4:0]  ex_rw,
        input logic [31:0] ex_d,
        input logic        mem_ok,
        input logic [4:0]  mem_rw,
        input logic [31:0] mem_d,
        input logic        wb_ok,
        input logic [4:0]  wb_rw,
        input logic [31:0] wb_d
    );
        logic [31:0] res;
        res = rf_d;
        if (r != 5'd0) begin
            if (ex_ok && ex_rw == r)        res = ex_d;
            else if (mem_ok && mem_rw == r) res = mem_d;
            else if (wb_ok && wb_rw == r)   res = wb_d;
        end
        return res;
    endfunction

    logic        ex_fwd_ok;
    logic        mem_fwd_ok;
    logic        wb_fwd_ok;
    logic [31:0] fwd_a;
    logic [31:0] fwd_b;
    logic [4:0]  id_rw;
    logic        load_use;

    // Resolve forwarded operands, the ID destination register and the load-use stall.
    always_comb begin
        ex_fwd_ok  = out_valid && out_ctrl[1] && (out_rw != 5'd0);
        mem_fwd_ok = in_mem_wr && (in_mem_rw != 5'd0);
        wb_fwd_ok  = in_wb_wr && (in_wb_rw != 5'd0);
        fwd_a = pick_operand(in_ra, in_A, ex_fwd_ok, out_rw, in_ex_R,
                             mem_fwd_ok, in_mem_rw, in_mem_R, wb_fwd_ok, in_wb_rw, in_wb_W);
        fwd_b = pick_operand(in_rb, in_B, ex_fwd_ok, out_rw, in_ex_R,
                             mem_fwd_ok, in_mem_rw, in_mem_R, wb_fwd_ok, in_wb_rw, in_wb_W);
        // Control bit 2 selects rd (R-type) over rt as the destination.
        id_rw = in_ctrl[2] ? in_IDIS[15:11] : in_IDIS[20:16];
        // A load in EX whose result is needed now cannot be forwarded in time.
        load_use = out_valid && out_ctrl[0] && (out_rw != 5'd0) &&
                   ((in_use_a && in_ra == out_rw) || (in_use_b && in_rb == out_rw));
        // A flush or hold already takes the edge, so no stall is raised then.
        out_stall = load_use && !in_flush && !in_hold;
    end

    // One action per edge: reset, hold, flush bubble, stall bubble, or normal load.
    always_ff @(posedge in_clk) begin
        if (in_RST) begin
            out_A       <= '0;
            out_B       <= '0;
            out_PC      <= '0;
            out_IS      <= '0;
            out_ctrl    <= '0;
            out_rw      <= '0;
            out_valid   <= 1'b0;
            out_bubbles <= '0;
            out_flushes <= '0;
        end else if (in_hold) begin
            out_A <= out_A;
        end else if (in_flush || out_stall) begin
            // Bubble keeps the ID PC so an exception in the slot still has a valid EPC.
            out_A     <= '0;
            out_B     <= '0;
            out_PC    <= in_IDPCOUT;
            out_IS    <= '0;
            out_ctrl  <= '0;
            out_rw    <= '0;
            out_valid <= 1'b0;
            if (in_flush) begin
                if (out_flushes != '1) out_flushes <= out_flushes + CNT_ONE;
            end else begin
                if (out_bubbles != '1) out_bubbles <= out_bubbles + CNT_ONE;
            end
        end else begin
            out_A     <= fwd_a;
            out_B     <= fwd_b;
            out_PC    <= in_IDPCOUT;
            out_IS    <= in_IDIS;
            out_ctrl  <= in_ctrl;
            out_rw    <= id_rw;
            out_valid <= 1'b1;
        end
    end

endmodule
